opr_operand_demux: RTL and testbench

//  - Routes one operand from the instruction decoder to exactly one of four execution units: WTR, INC, RESET or WTA.
//  - The unit is chosen by the 3-bit OPR select field.
//  - Sits between the operand field of the decoder and the operand inputs of the execution units.
//  - Outputs are registered: one-cycle latency, glitch-free unit inputs.

---
 rtl/opr_operand_demux.sv | 116 +++++++++++
 tb/tb_opr_operand_demux.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/opr_operand_demux.sv
// opr_operand_demux
// Routes one decoder operand to exactly one of four execution units
// (WTR, INC, RESET, WTA) chosen by the OPR select field. All outputs are
// registered, so the unit inputs are glitch-free and lag the inputs by one
// clock. Select codes 0..3 are legal; any other code, including an unknown
// one, is illegal. An illegal code routes nowhere and raises io_sel_err for
// one cycle.
//
// Build option (macro OPR_DEMUX_HOLD_EN):
//   undefined : non-selected outputs are forced to 0 every cycle and an
//               illegal select zeroes all four outputs.
//   defined   : non-selected outputs keep their last value, and an illegal
//               select leaves all four unchanged. io_sel_err still sets.
//               Reset still clears everything.

module opr_operand_demux #(
    parameter int WIDTH     = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     io_operand,
    input  logic [SEL_WIDTH-1:0] io_OPR_sel,
    output logic [WIDTH-1:0]     io_WTR_operand,
    output logic [WIDTH-1:0]     io_INC_operand,
    output logic [WIDTH-1:0]     io_RESET_operand,
    output logic [WIDTH-1:0]     io_WTA_operand,
    output logic                 io_sel_err
);

    localparam int NUM_UNITS = 4;

    // Destination units. The enum value is also the index into the operand
    // register array and the legal select code for that unit.
    typedef enum logic [1:0] {
        UNIT_WTR   = 2'd0,
        UNIT_INC   = 2'd1,
        UNIT_RESET = 2'd2,
        UNIT_WTA   = 2'd3
    } unit_e;

    logic [NUM_UNITS-1:0] unitHit;
    logic                 selLegal;

    logic [WIDTH-1:0] unitOperand_q [NUM_UNITS];
    logic [WIDTH-1:0] unitOperand_d [NUM_UNITS];
    logic             selErr_q;
    logic             selErr_d;

    // Decode the select field into a one-hot unit strobe; anything that is
    // not exactly 0..3 (including an unknown value) falls into the default.
    always_comb begin
        unitHit  = '0;
        selLegal = 1'b0;
        case (io_OPR_sel)
            SEL_WIDTH'(UNIT_WTR): begin
                unitHit[UNIT_WTR] = 1'b1;
                selLegal          = 1'b1;
            end
            SEL_WIDTH'(UNIT_INC): begin
                unitHit[UNIT_INC] = 1'b1;
                selLegal          = 1'b1;
            end
            SEL_WIDTH'(UNIT_RESET): begin
                unitHit[UNIT_RESET] = 1'b1;
                selLegal            = 1'b1;
            end
            SEL_WIDTH'(UNIT_WTA): begin
                unitHit[UNIT_WTA] = 1'b1;
                selLegal          = 1'b1;
            end
            default: begin
                unitHit  = '0;
                selLegal = 1'b0;
            end
        endcase
    end

    // Next value for each unit register: the selected unit takes the
    // operand bit-exact, the others either clear or hold depending on build.
    always_comb begin
        for (int u = 0; u < NUM_UNITS; u++) begin
`ifdef OPR_DEMUX_HOLD_EN
            unitOperand_d[u] = unitOperand_q[u];
`else
            unitOperand_d[u] = '0;
`endif
            if (unitHit[u]) begin
                unitOperand_d[u] = io_operand;
            end
        end
        selErr_d = ~selLegal;
    end

    // Output registers with synchronous reset taking priority over routing.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unitOperand_q[u] <= '0;
            end
            selErr_q <= 1'b0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                unitOperand_q[u] <= unitOperand_d[u];
            end
            selErr_q <= selErr_d;
        end
    end

    assign io_WTR_operand   = unitOperand_q[UNIT_WTR];
    assign io_INC_operand   = unitOperand_q[UNIT_INC];
    assign io_RESET_operand = unitOperand_q[UNIT_RESET];
    assign io_WTA_operand   = unitOperand_q[UNIT_WTA];
    assign io_sel_err       = selErr_q;

endmodule

// File: tb/tb_opr_operand_demux.sv
// tb_opr_operand_demux
// Directed bench for opr_operand_demux. A behavioural model of the routing
// rules runs alongside the DUT and every cycle's outputs are compared to it;
// literal expectations at key points pin the model itself. Honors
// OPR_DEMUX_HOLD_EN the same way the design does.

module tb_opr_operand_demux;

    logic       clock;
    logic       reset;
    logic [7:0] io_operand;
    logic [2:0] io_OPR_sel;
    logic [7:0] io_WTR_operand;
    logic [7:0] io_INC_operand;
    logic [7:0] io_RESET_operand;
    logic [7:0] io_WTA_operand;
    logic       io_sel_err;

    int passCount  = 0;
    int checkCount = 0;

    logic [7:0] expOp [4];
    logic       expErr;
    bit         modelValid = 1'b0;

    opr_operand_demux #(.WIDTH(8), .SEL_WIDTH(3)) dut (
        .clock            (clock),
        .reset            (reset),
        .io_operand       (io_operand),
        .io_OPR_sel       (io_OPR_sel),
        .io_WTR_operand   (io_WTR_operand),
        .io_INC_operand   (io_INC_operand),
        .io_RESET_operand (io_RESET_operand),
        .io_WTA_operand   (io_WTA_operand),
        .io_sel_err       (io_sel_err)
    );

    // Free-running 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual=%0h required=%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkAll(input string name, input logic [7:0] wtr,
                            input logic [7:0] inc, input logic [7:0] rst,
                            input logic [7:0] wta, input logic err);
        checkOutput({name, ".WTR"},   io_WTR_operand,   wtr);
        checkOutput({name, ".INC"},   io_INC_operand,   inc);
        checkOutput({name, ".RESET"}, io_RESET_operand, rst);
        checkOutput({name, ".WTA"},   io_WTA_operand,   wta);
        checkOutput({name, ".ERR"},   io_sel_err,       err);
    endtask

    // Drive one cycle's inputs mid-cycle, then wait past the capturing edge.
    task automatic applyStimulus(input logic rst, input logic [7:0] op,
                                 input logic [2:0] sel);
        reset      = rst;
        io_operand = op;
        io_OPR_sel = sel;
        @(posedge clock);
        @(negedge clock);
    endtask

    // Reference model: what each unit must hold after this edge.
    always @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) expOp[k] = 8'h00;
            expErr = 1'b0;
        end else if (io_OPR_sel < 3'd4) begin
`ifndef OPR_DEMUX_HOLD_EN
            for (int k = 0; k < 4; k++) expOp[k] = 8'h00;
`endif
            expOp[io_OPR_sel] = io_operand;
            expErr = 1'b0;
        end else begin
`ifndef OPR_DEMUX_HOLD_EN
            for (int k = 0; k < 4; k++) expOp[k] = 8'h00;
`endif
            expErr = 1'b1;
        end
        modelValid = 1'b1;
    end

    // Compare DUT to model every cycle, away from the active edge.
    always @(negedge clock) begin
        if (modelValid) begin
            checkAll("model", expOp[0], expOp[1], expOp[2], expOp[3], expErr);
        end
    end

    initial begin
        reset      = 1'b1;
        io_operand = 8'd6;
        io_OPR_sel = 3'd0;
        @(negedge clock);

        applyStimulus(1'b1, 8'd6, 3'd0);
        applyStimulus(1'b1, 8'd6, 3'd0);
        checkAll("reset", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);

`ifndef OPR_DEMUX_HOLD_EN
        applyStimulus(1'b0, 8'd6, 3'd0);
        checkAll("sweep0", 8'd6, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd6, 3'd1);
        checkAll("sweep1", 8'd0, 8'd6, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd6, 3'd2);
        checkAll("sweep2", 8'd0, 8'd0, 8'd6, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd6, 3'd3);
        checkAll("sweep3", 8'd0, 8'd0, 8'd0, 8'd6, 1'b0);

        applyStimulus(1'b0, 8'd6, 3'd4);
        checkAll("illegal4", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd6, 3'd5);
        checkAll("illegal5", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'd6, 3'd1);
        checkAll("recover", 8'd0, 8'd6, 8'd0, 8'd0, 1'b0);

        applyStimulus(1'b0, 8'hA5, 3'd0);
        checkAll("b2b1", 8'hA5, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'h3C, 3'd3);
        checkAll("b2b2", 8'd0, 8'd0, 8'd0, 8'h3C, 1'b0);

        applyStimulus(1'b0, 8'd6, 3'd2);
        checkAll("midrst0", 8'd0, 8'd0, 8'd6, 8'd0, 1'b0);
        applyStimulus(1'b1, 8'd6, 3'd2);
        checkAll("midrst1", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd6, 3'd2);
        checkAll("midrst2", 8'd0, 8'd0, 8'd6, 8'd0, 1'b0);

        applyStimulus(1'b0, 8'hFF, 3'd3);
        checkAll("allones", 8'd0, 8'd0, 8'd0, 8'hFF, 1'b0);
        applyStimulus(1'b0, 8'h00, 3'd1);
        checkAll("zeroop", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'h81, 3'd7);
        checkAll("illegal7", 8'd0, 8'd0, 8'd0, 8'd0, 1'b1);
`else
        applyStimulus(1'b0, 8'd6, 3'd0);
        checkAll("hold0", 8'd6, 8'd0, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'd9, 3'd1);
        checkAll("hold1", 8'd6, 8'd9, 8'd0, 8'd0, 1'b0);
        applyStimulus(1'b0, 8'h55, 3'd7);
        checkAll("hold7", 8'd6, 8'd9, 8'd0, 8'd0, 1'b1);
        applyStimulus(1'b0, 8'h3C, 3'd3);
        checkAll("hold3", 8'd6, 8'd9, 8'd0, 8'h3C, 1'b0);
        applyStimulus(1'b1, 8'd6, 3'd2);
        checkAll("holdrst", 8'd0, 8'd0, 8'd0, 8'd0, 1'b0);
`endif

        // Random back-to-back traffic, checked by the per-cycle model compare.
        for (int i = 0; i < 200; i++) begin
            applyStimulus(($urandom_range(0, 19) == 0), 8'($urandom()),
                          3'($urandom_range(0, 7)));
        end

        modelValid = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
